// File: rtl/mem_block_reader.sv
// Block fetch engine: reads a 4-word aligned block from a 32K x 32 backing
// store after a configurable wait and presents it for a cache fill.
module mem_block_reader #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [14:0] req_addr,
  input  logic        wr_en,
  input  logic [14:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        fill_write,
  output logic [14:0] fill_addr,
  output logic [31:0] D1,
  output logic [31:0] D2,
  output logic [31:0] D3,
  output logic [31:0] D4
);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [1:0]  beat_cnt;
  logic [31:0] mem [0:32767];
  logic [31:0] rd_word;

  // Backing store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Single read path: the current beat's word within the latched block.
  // Read is combinational so a same-edge write is seen only by later beats.
  always_comb begin
    rd_word = mem[{fill_addr[14:2], beat_cnt}];
  end

  // Fetch sequencer with registered status and data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      fill_write <= 1'b0;
      fill_addr  <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      D1         <= '0;
      D2         <= '0;
      D3         <= '0;
      D4         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            fill_addr <= {req_addr[14:2], 2'b00};
            wait_cnt  <= '0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'(LATENCY - 1)) begin
            beat_cnt <= '0;
            state    <= BEAT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        BEAT: begin
          case (beat_cnt)
            2'd0:    D1 <= rd_word;
            2'd1:    D2 <= rd_word;
            2'd2:    D3 <= rd_word;
            default: D4 <= rd_word;
          endcase
          if (beat_cnt == 2'd3) begin
            fill_write <= 1'b1;
            state      <= DONE;
          end else begin
            beat_cnt <= beat_cnt + 2'd1;
          end
        end
        DONE: begin
          fill_write <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_reader.sv
// Scoreboard bench for mem_block_reader: per-cycle timing/data checks in the
// fetch task, block contents checked by a monitor on every fill_write pulse.
module tb_mem_block_reader;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [14:0] req_addr;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        fill_write;
  logic [14:0] fill_addr;
  logic [31:0] D1, D2, D3, D4;

  mem_block_reader #(.LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .fill_write (fill_write),
    .fill_addr  (fill_addr),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .D4         (D4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0]      addr;
    logic [3:0][31:0] d;
  } blk_t;

  blk_t        sb_q[$];
  logic [31:0] model [0:32767];
  logic [3:0][31:0] prev_d;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every fill pulse must match the oldest expected block.
  always @(posedge clk) begin
    #1;
    if (!rst && fill_write) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_fill", 32'd1, 32'd0);
      end else begin
        blk_t e;
        e = sb_q.pop_front();
        check_eq("sb_fill_addr", 32'(fill_addr), 32'(e.addr));
        check_eq("sb_D1", D1, e.d[0]);
        check_eq("sb_D2", D2, e.d[1]);
        check_eq("sb_D3", D3, e.d[2]);
        check_eq("sb_D4", D4, e.d[3]);
      end
    end
  end

  task automatic wr_word(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One complete fetch: optional single write at edge wr_edge (0 = none) and
  // extra req pulses at the edges flagged in req_mask (edge 0 = accept edge).
  task automatic fetch(input logic [14:0] a, input int unsigned wr_edge,
                       input logic [14:0] wa, input logic [31:0] wd,
                       input logic [31:0] req_mask);
    blk_t e;
    logic [3:0][31:0] ed;
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (wr_edge != 0 && wa == base + 15'(k) && wr_edge < L + 1 + k)
        ed[k] = wd;
      else
        ed[k] = model[base + 15'(k)];
    end
    e.addr = base;
    e.d    = ed;
    sb_q.push_back(e);
    if (wr_edge != 0) model[wa] = wd;

    @(negedge clk);
    req = 1'b1; req_addr = a;
    @(posedge clk);
    #1;
    check_eq("busy_rise", 32'(busy), 32'd1);
    check_eq("addr_latch", 32'(fill_addr), 32'(base));
    for (int unsigned i = 1; i <= L + 5; i++) begin
      @(negedge clk);
      req     = req_mask[i];
      wr_en   = (i == wr_edge);
      wr_addr = wa;
      wr_data = wd;
      @(posedge clk);
      #1;
      check_eq("busy", 32'(busy), 32'(i < L + 5));
      check_eq("fill_write", 32'(fill_write), 32'(i == L + 4));
      check_eq("fill_addr", 32'(fill_addr), 32'(base));
      check_eq("D1_cyc", D1, (i >= L + 1) ? ed[0] : prev_d[0]);
      check_eq("D2_cyc", D2, (i >= L + 2) ? ed[1] : prev_d[1]);
      check_eq("D3_cyc", D3, (i >= L + 3) ? ed[2] : prev_d[2]);
      check_eq("D4_cyc", D4, (i >= L + 4) ? ed[3] : prev_d[3]);
    end
    @(negedge clk);
    req = 1'b0; wr_en = 1'b0;
    prev_d = ed;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    prev_d = '0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fill_write", 32'(fill_write), 32'd0);
    check_eq("rst_fill_addr", 32'(fill_addr), 32'd0);
    check_eq("rst_D1", D1, 32'd0);
    check_eq("rst_D4", D4, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      wr_word(15'h0100 + 15'(k), 32'h0000_00A0 + 32'(k));
      wr_word(15'h7FFC + 15'(k), 32'h7FFC_0000 + 32'(k));
      wr_word(15'h0000 + 15'(k), 32'h1111_0000 + 32'(k));
      wr_word(15'h0200 + 15'(k), 32'h0000_00B0 + 32'(k));
    end

    // Basic fetch from an unaligned address within block 0x0100.
    fetch(15'h0102, 0, '0, '0, '0);
    // Top block, must not wrap to 0x0000.
    fetch(15'h7FFE, 0, '0, '0, '0);
    // Same-edge write on the beat-2 capture: old value captured.
    fetch(15'h0100, L + 3, 15'h0102, 32'h0000_DEAD, '0);
    // Re-fetch sees the new value.
    fetch(15'h0101, 0, '0, '0, '0);
    // Write during WAIT to a block word is reflected.
    fetch(15'h0103, 2, 15'h0101, 32'h5555_AAAA, '0);
    // Different block, extra req pulses at edges 2 and 5 ignored.
    fetch(15'h0200, 0, '0, '0, 32'h0000_0024);

    // Reset during WAIT aborts with no fill pulse.
    @(negedge clk);
    req = 1'b1; req_addr = 15'h0201;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_fill_write", 32'(fill_write), 32'd0);
    check_eq("abort_fill_addr", 32'(fill_addr), 32'd0);
    check_eq("abort_D1", D1, 32'd0);
    check_eq("abort_D2", D2, 32'd0);
    check_eq("abort_D3", D3, 32'd0);
    check_eq("abort_D4", D4, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_d = '0;
    for (int unsigned i = 0; i < L + 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_after_abort", 32'(busy), 32'd0);
    end

    // Memory survived reset.
    fetch(15'h0100, 0, '0, '0, '0);
    fetch(15'h0003, 0, '0, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_block_reader.md
MEM_BLOCK_READER -- requirements
Module: mem_block_reader

Interface
REQ-001 Parameter: LATENCY, 4, wait cycles before the first word beat (legal range 1..15).
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: req  input  1  block-fetch request, sampled only in IDLE.
REQ-005 Port: req_addr  input  15  word address; block base = {req_addr[14:2], 2'b00}.
REQ-006 Port: wr_en  input  1  backing-store word write enable.
REQ-007 Port: wr_addr  input  15  backing-store word write address.
REQ-008 Port: wr_data  input  32  backing-store word write data.
REQ-009 Port: busy  output  1  high while a fetch is in progress (any state other than IDLE).
REQ-010 Port: fill_write  output  1  one-cycle pulse; the block on D1..D4 is valid for the cache write port.
REQ-011 Port: fill_addr  output  15  latched block base address of the current/last fetch.
REQ-012 Port: D1, D2, D3, D4  output  32 each  words at block base +0, +1, +2, +3.

Function
REQ-013 Backing store SHALL be 32768 x 32-bit words, single read path, one word read per cycle.
REQ-014 wr_en high at an edge SHALL write wr_data to word wr_addr, in any state.
REQ-015 Backing-store contents SHALL NOT be cleared by rst.
REQ-016 States SHALL be IDLE, WAIT, BEAT, DONE.
REQ-017 IDLE with req=1 at edge E0 SHALL latch fill_addr = block base, clear the wait counter, and go to WAIT.
REQ-018 IDLE with req=0 SHALL hold all outputs.
REQ-019 WAIT SHALL last exactly LATENCY cycles, then go to BEAT with beat counter = 0.
REQ-020 BEAT SHALL last 4 cycles; beat k (0..3) SHALL capture word fill_addr+k into D(k+1) at its edge.
REQ-021 After beat 3, state SHALL go to DONE.
REQ-022 DONE SHALL drive fill_write=1 for exactly one cycle, then go to IDLE.
REQ-023 fill_write SHALL rise LATENCY+4 edges after E0 and fall at edge LATENCY+5.
REQ-024 busy SHALL rise at E0 and fall at edge LATENCY+5.
REQ-025 req while busy=1 SHALL be ignored and not queued.
REQ-026 A new req may be accepted at the edge on which DONE exits (IDLE in the next cycle only if req is sampled in IDLE; no back-to-back acceptance within DONE).
REQ-027 D1..D4 and fill_addr SHALL hold stable from DONE until overwritten by the next fetch's capture/latch.
REQ-028 Read-before-write: wr_en to the word being captured on the same edge SHALL yield the old value in D(k+1); the new value applies to later reads.
REQ-029 wr_en to a block word before its beat edge SHALL be reflected in the captured data.
REQ-030 Block words SHALL never cross a 4-word boundary; no address wrap logic beyond the 15-bit width.
REQ-031 The wait counter and beat counter SHALL be sized for their maximum value, with no wrap inside a state.

Reset
REQ-032 rst=1 SHALL force state IDLE, busy=0, fill_write=0, fill_addr=0, D1..D4=0, and both counters=0 immediately, without waiting for a clock edge.
REQ-033 rst asserted mid-fetch SHALL abort the fetch with no fill_write pulse; the first req after deassertion starts a fresh fetch.

Verification
REQ-034 Preload words 0x0100..0x0103 = 0xA0,0xA1,0xA2,0xA3; req with req_addr=0x0102 (LATENCY=4) -> fill_addr=0x0100, D1..D4=0xA0..0xA3, fill_write high exactly in cycle 8 after the req edge, busy deasserted at edge 9.
REQ-035 Fetch block 0x7FFC -> D1..D4 = words 0x7FFC..0x7FFF, no wrap to 0x0000.
REQ-036 During BEAT, wr_en to word base+2 on the beat-2 edge with 0xDEAD -> D3 = old value; re-fetch -> D3 = 0xDEAD.
REQ-037 Pulse req again at edges 2 and 5 of an active fetch -> exactly one fill_write pulse; busy stays continuous for a single fetch.
REQ-038 Assert rst during WAIT -> busy=0 and D1..D4=0 immediately, no fill_write pulse; a subsequent req completes normally, with preloaded memory contents intact.
REQ-039 Two consecutive fetches of different blocks -> D1..D4 hold the first block until its words are overwritten beat by beat; fill_addr updates at the second req edge.
